// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;
  localparam logic [31:0] BUBBLE_INST      = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PENDING = 2'd1,
    ST_READY   = 2'd2
  } ent_st_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/ifetch_buf.sv
// In-order fetch buffer: entries are allocated on request accept, filled on
// response, popped at the head. head <= fill <= tail always holds.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      alloc_i,
  input  logic [31:0]               alloc_pc_i,
  input  logic                      fill_i,
  input  logic [31:0]               fill_inst_i,
  input  logic                      pop_i,
  output logic                      head_ready_o,
  output logic [31:0]               head_pc_o,
  output logic [31:0]               head_inst_o,
  output logic [ptr_w(DEPTH):0]     occ_o,
  output logic [ptr_w(DEPTH):0]     pend_o
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PONE = 1;

  ent_st_e [DEPTH-1:0]        st_q;
  logic    [DEPTH-1:0][31:0]  pc_q;
  logic    [DEPTH-1:0][31:0]  inst_q;
  logic    [PW-1:0]           head_q, fptr_q, tail_q;
  logic    [CW-1:0]           occ_q, pend_q;

  // Alloc is applied last so it wins if tail and head coincide on a full pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= {DEPTH{ST_EMPTY}};
      pc_q   <= '0;
      inst_q <= '0;
      head_q <= '0;
      fptr_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      pend_q <= '0;
    end else if (clear_i) begin
      st_q   <= {DEPTH{ST_EMPTY}};
      head_q <= '0;
      fptr_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      pend_q <= '0;
    end else begin
      if (fill_i) begin
        st_q[fptr_q]   <= ST_READY;
        inst_q[fptr_q] <= fill_inst_i;
        fptr_q         <= fptr_q + PONE;
      end
      if (pop_i) begin
        st_q[head_q] <= ST_EMPTY;
        head_q       <= head_q + PONE;
      end
      if (alloc_i) begin
        st_q[tail_q] <= ST_PENDING;
        pc_q[tail_q] <= alloc_pc_i;
        tail_q       <= tail_q + PONE;
      end
      occ_q  <= occ_q + CW'(alloc_i) - CW'(pop_i);
      pend_q <= pend_q + CW'(alloc_i) - CW'(fill_i);
    end
  end

  assign head_ready_o = (st_q[head_q] == ST_READY);
  assign head_pc_o    = pc_q[head_q];
  assign head_inst_o  = inst_q[head_q];
  assign occ_o        = occ_q;
  assign pend_o       = pend_q;
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: sequential PC generation, imem req/gnt/rvalid
// handshake, in-order buffering and IF/ID presentation with flush draining.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pause_flag,
  input  logic        flush_flag,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);
  localparam int CW = ptr_w(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] occ, pend;
  logic          head_ready;
  logic [31:0]   head_pc, head_inst;
  logic          accept, fill, pop, drop_rv;

  ifetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush_flag),
    .alloc_i     (accept),
    .alloc_pc_i  (fetch_pc_q),
    .fill_i      (fill),
    .fill_inst_i (imem_rdata),
    .pop_i       (pop),
    .head_ready_o(head_ready),
    .head_pc_o   (head_pc),
    .head_inst_o (head_inst),
    .occ_o       (occ),
    .pend_o      (pend)
  );

  // Outstanding dropped responses still hold a slot of in-flight capacity.
  always_comb begin
    imem_req = rst_n && !flush_flag &&
               (({1'b0, occ} + {1'b0, drop_cnt_q}) < (CW+1)'(DEPTH));
    accept   = imem_req && imem_gnt;
    drop_rv  = imem_rvalid && !flush_flag && (drop_cnt_q != '0);
    fill     = imem_rvalid && !flush_flag && (drop_cnt_q == '0) && (pend != '0);
    pop      = head_ready && !pause_flag && !flush_flag;
  end

  // A response landing in a flush cycle retires one of the in-flight requests
  // being written off, so it is netted out of the new drop count.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (flush_flag) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_cnt_d = drop_cnt_q + pend -
                   CW'(imem_rvalid && ((drop_cnt_q != '0) || (pend != '0)));
    end else begin
      if (accept)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (drop_rv) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign if_valid  = head_ready;
  assign if_pc     = head_ready ? head_pc   : fetch_pc_q;
  assign if_inst   = head_ready ? head_inst : BUBBLE_INST;

  ast_rvalid_orphan: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((drop_cnt_q != '0) || (pend != '0)));
endmodule

// File: tb/tb_ifetch_unit.sv
// Cycle-exact check of ifetch_unit against a queue-based fetch model driven
// by an in-order memory with random grant/response timing.
module tb_ifetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk, rst_n;
  logic        pause_flag, flush_flag, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata, imem_addr, if_pc, if_inst;
  logic        imem_req, if_valid;

  ifetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pause_flag(pause_flag), .flush_flag(flush_flag),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          rdy;
  } ent_t;

  ent_t        mb[$];     // model buffer, oldest first
  logic [31:0] mq[$];     // memory: accepted addresses awaiting response
  logic [31:0] m_fpc;
  int          m_drop;
  int          vec, errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int npend();
    int n = 0;
    foreach (mb[i]) if (!mb[i].rdy) n++;
    return n;
  endfunction

  function automatic bit head_is(input logic [31:0] pc);
    return mb.size() > 0 && mb[0].rdy && mb[0].pc == pc;
  endfunction

  task automatic model_reset();
    mb.delete();
    mq.delete();
    m_fpc  = RPC;
    m_drop = 0;
  endtask

  // One clock cycle: drive at posedge+1, check mid-cycle, advance the model.
  task automatic step(input bit p, input bit f, input logic [31:0] rpc,
                      input bit g, input bit rv);
    bit          m_valid, m_req;
    logic [31:0] e_pc, e_inst;
    int          np;
    pause_flag  = p;
    flush_flag  = f;
    redirect_pc = rpc;
    imem_gnt    = g;
    imem_rvalid = rv && (mq.size() > 0);
    imem_rdata  = imem_rvalid ? (mq[0] ^ KEY) : $urandom;
    #2;
    m_valid = mb.size() > 0 && mb[0].rdy;
    m_req   = !f && (mb.size() + m_drop < DEPTH);
    e_pc    = m_valid ? mb[0].pc : m_fpc;
    e_inst  = m_valid ? mb[0].inst : 32'h0;
    chk("imem_req",  {31'b0, imem_req}, {31'b0, m_req});
    chk("imem_addr", imem_addr, m_fpc);
    chk("if_valid",  {31'b0, if_valid}, {31'b0, m_valid});
    chk("if_pc",     if_pc, e_pc);
    chk("if_inst",   if_inst, e_inst);
    if (f) begin
      np = npend();
      m_drop = m_drop + np - ((imem_rvalid && (m_drop + np > 0)) ? 1 : 0);
      mb.delete();
      m_fpc = {rpc[31:2], 2'b00};
    end else begin
      if (imem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mb.size(); i++)
            if (!mb[i].rdy) begin
              mb[i].rdy  = 1'b1;
              mb[i].inst = imem_rdata;
              break;
            end
        end
      end
      if (m_valid && !p) void'(mb.pop_front());
      if (m_req && g) begin
        mb.push_back('{pc: m_fpc, inst: 32'h0, rdy: 1'b0});
        m_fpc = m_fpc + 32'd4;
      end
    end
    if (imem_rvalid) void'(mq.pop_front());
    if (imem_req && imem_gnt) mq.push_back(imem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic zw(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 1, 1);
  endtask

  // Assert reset mid-cycle, check outputs before any clock edge, then release.
  task automatic do_reset();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    pause_flag  = 1'b0;
    flush_flag  = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, RPC);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_pc",    if_pc, RPC);
    chk("rst_inst",  if_inst, 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec = 0;
    errs = 0;
    rst_n = 1'b1;
    redirect_pc = 32'h0;
    imem_rdata = 32'h0;
    @(posedge clk);
    #1;
    do_reset();

    // zero-wait startup until the instruction at 8 is presented, then pause
    for (int i = 0; i < 20; i++) begin
      if (head_is(32'h8)) break;
      step(0, 0, 32'h0, 1, 1);
    end
    chk("reach_pc8", {31'b0, head_is(32'h8)}, 32'h1);
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1, 1);
    zw(6);

    // build two pending requests, then flush to 0x103
    for (int i = 0; i < 10; i++) begin
      if (npend() == 2) break;
      step(0, 0, 32'h0, 1, 0);
    end
    chk("two_pending", npend(), 32'd2);
    step(0, 1, 32'h103, 1, 1);
    zw(10);

    // grant withheld four cycles
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1);
    zw(6);

    // flush and pause together, then redirect to the top of the address space
    step(1, 1, 32'h200, 1, 1);
    zw(6);
    step(0, 1, 32'hFFFF_FFFC, 1, 1);
    zw(8);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) == 0, ($urandom % 20) == 0, $urandom,
           ($urandom % 10) < 7, ($urandom % 10) < 7);

    // mid-stream reset, restart from RESET_PC
    zw(3);
    do_reset();
    zw(8);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
